// File: rtl/fm_spy_mem_ctrl_if.sv
// fm_spy_mem_ctrl_if: AXI-side request/response and spy-buffer port bundle for fm_spy_mem_ctrl.
interface fm_spy_mem_ctrl_if #(
    parameter int N_CH   = 32,
    parameter int AXI_DW = 32,
    parameter int ADDR_W = 10,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic                   req_vld;
    logic                   req_wr;
    logic [CH_W-1:0]        req_ch;
    logic [ADDR_W-1:0]      req_addr;
    logic [AXI_DW-1:0]      req_wdata;
    logic                   req_ack;
    logic                   rd_vld;
    logic [AXI_DW-1:0]      rd_data;
    logic                   rd_err;
    logic [N_CH-1:0]        sb_en;
    logic [N_CH-1:0]        sb_wr_en;
    logic [ADDR_W-1:0]      sb_addr;
    logic [AXI_DW-1:0]      sb_wr_data;
    logic [N_CH*AXI_DW-1:0] sb_rd_data;

    // master is the surrounding system: register decode plus the spy-buffer array
    modport master (
        output req_vld, req_wr, req_ch, req_addr, req_wdata, sb_rd_data,
        input  req_ack, rd_vld, rd_data, rd_err, sb_en, sb_wr_en, sb_addr, sb_wr_data
    );
    modport slave (
        input  req_vld, req_wr, req_ch, req_addr, req_wdata, sb_rd_data,
        output req_ack, rd_vld, rd_data, rd_err, sb_en, sb_wr_en, sb_addr, sb_wr_data
    );
endinterface

// File: rtl/fm_spy_mem_ctrl.sv
// fm_spy_mem_ctrl: spy-buffer init sequencer and request arbiter with fixed read latency.
// Define FM_SPY_INIT_ADDR_PATTERN_EN to XOR the init fill word with the address.
module fm_spy_mem_ctrl #(
    parameter int          N_CH         = 32,
    parameter int          AXI_DW       = 32,
    parameter int          ADDR_W       = 10,
    parameter int          RD_LAT       = 1,
    parameter logic [31:0] INIT_PATTERN = 32'h0FA5FA50,
    parameter int          CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             spy_clock,
    input  logic             axi_reset_n,
    input  logic             init_start,
    output logic             init_busy,
    output logic             init_done,
    fm_spy_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, RD, WR} state_t;

    localparam logic [AXI_DW-1:0] PAT  = AXI_DW'(INIT_PATTERN);
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic              pend_init;
    logic [2:0]        lat_cnt;
    logic [CH_W-1:0]   cap_ch;
    logic              cap_bad;
    logic [N_CH-1:0]   ch_oh;
    logic              ch_bad;
    logic [AXI_DW-1:0] rd_slice;
    logic [ADDR_W-1:0] nxt_addr;
    logic [AXI_DW-1:0] init_word;

    // out-of-range channels decode to no strobe and an all-zero read slice
    always_comb begin
        ch_oh    = '0;
        rd_slice = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_oh[i] = bus.req_ch == CH_W'(i);
            if (cap_ch == CH_W'(i)) rd_slice = bus.sb_rd_data[i*AXI_DW +: AXI_DW];
        end
    end

    assign ch_bad   = ~|ch_oh;
    assign nxt_addr = (state == INIT) ? bus.sb_addr + ADDR_W'(1) : '0;

`ifdef FM_SPY_INIT_ADDR_PATTERN_EN
    assign init_word = PAT ^ AXI_DW'(nxt_addr);
`else
    assign init_word = PAT;
`endif

    always_ff @(posedge spy_clock) begin
        if (!axi_reset_n) begin
            state          <= IDLE;
            pend_init      <= 1'b0;
            lat_cnt        <= '0;
            cap_ch         <= '0;
            cap_bad        <= 1'b0;
            init_busy      <= 1'b0;
            init_done      <= 1'b0;
            bus.req_ack    <= 1'b0;
            bus.rd_vld     <= 1'b0;
            bus.rd_data    <= '0;
            bus.rd_err     <= 1'b0;
            bus.sb_en      <= '0;
            bus.sb_wr_en   <= '0;
            bus.sb_addr    <= '0;
            bus.sb_wr_data <= '0;
        end else begin
            bus.req_ack    <= 1'b0;
            bus.rd_vld     <= 1'b0;
            bus.rd_data    <= '0;
            bus.rd_err     <= 1'b0;
            bus.sb_en      <= '0;
            bus.sb_wr_en   <= '0;
            bus.sb_addr    <= '0;
            bus.sb_wr_data <= '0;
            case (state)
                IDLE: begin
                    if (init_start || pend_init) begin
                        state          <= INIT;
                        pend_init      <= 1'b0;
                        init_busy      <= 1'b1;
                        init_done      <= 1'b0;
                        bus.sb_en      <= '1;
                        bus.sb_wr_en   <= '1;
                        bus.sb_addr    <= nxt_addr;
                        bus.sb_wr_data <= init_word;
                    end else if (bus.req_vld) begin
                        state       <= bus.req_wr ? WR : RD;
                        bus.req_ack <= 1'b1;
                        bus.sb_en   <= ch_oh;
                        bus.sb_addr <= bus.req_addr;
                        cap_ch      <= bus.req_ch;
                        cap_bad     <= ch_bad;
                        lat_cnt     <= '0;
                        if (bus.req_wr) begin
                            bus.sb_wr_en   <= ch_oh;
                            bus.sb_wr_data <= bus.req_wdata;
                        end
                    end
                end
                INIT: begin
                    if (bus.sb_addr == LAST) begin
                        state     <= IDLE;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        bus.sb_en      <= '1;
                        bus.sb_wr_en   <= '1;
                        bus.sb_addr    <= nxt_addr;
                        bus.sb_wr_data <= init_word;
                    end
                end
                WR: begin
                    state     <= IDLE;
                    pend_init <= pend_init | init_start;
                end
                default: begin
                    pend_init <= pend_init | init_start;
                    // ack cycle counts as lat 0; data is sampled RD_LAT cycles later
                    if (lat_cnt == 3'(RD_LAT)) begin
                        state       <= IDLE;
                        bus.rd_vld  <= 1'b1;
                        bus.rd_data <= rd_slice;
                        bus.rd_err  <= cap_bad;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fm_spy_mem_ctrl.sv
// tb_fm_spy_mem_ctrl: directed self-checking bench for fm_spy_mem_ctrl with a latency-1 spy memory stub.
module tb_fm_spy_mem_ctrl;
    localparam int N_CH   = 4;
    localparam int AXI_DW = 32;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 1;
    localparam int CH_W   = 3;

`ifdef FM_SPY_INIT_ADDR_PATTERN_EN
    localparam bit ADDR_TAG = 1'b1;
`else
    localparam bit ADDR_TAG = 1'b0;
`endif

    logic spy_clock   = 1'b0;
    logic axi_reset_n = 1'b0;
    logic init_start  = 1'b0;
    logic init_busy;
    logic init_done;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    fm_spy_mem_ctrl_if #(.N_CH(N_CH), .AXI_DW(AXI_DW), .ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

    fm_spy_mem_ctrl #(
        .N_CH(N_CH), .AXI_DW(AXI_DW), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
        .INIT_PATTERN(32'h0FA5FA50), .CH_W(CH_W)
    ) dut (
        .spy_clock  (spy_clock),
        .axi_reset_n(axi_reset_n),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .bus        (bus.slave)
    );

    always #5 spy_clock = ~spy_clock;
    always @(posedge spy_clock) cyc <= cyc + 1;

    // spy buffer stub: registered read, one cycle latency
    logic [31:0]  mem [N_CH][16];
    logic [127:0] rd_q = '0;
    always @(posedge spy_clock)
        for (int c = 0; c < N_CH; c++)
            if (bus.sb_en[c]) begin
                if (bus.sb_wr_en[c]) mem[c][bus.sb_addr] <= bus.sb_wr_data;
                else rd_q[c*32 +: 32] <= mem[c][bus.sb_addr];
            end
    assign bus.sb_rd_data = rd_q;

    logic [9:0] outs;
    assign outs = {init_busy, init_done, bus.req_ack, bus.rd_vld, bus.rd_err, |bus.rd_data,
                   |bus.sb_en, |bus.sb_wr_en, |bus.sb_addr, |bus.sb_wr_data};

    function automatic logic [31:0] exp_init(input int a);
        return ADDR_TAG ? (32'h0FA5FA50 ^ 32'(a)) : 32'h0FA5FA50;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic start_req(input logic wr, input logic [CH_W-1:0] ch, input logic [3:0] addr,
                             input logic [31:0] data);
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_ch    = ch;
        bus.req_addr  = addr;
        bus.req_wdata = data;
    endtask

    task automatic wait_ack(input string tag, input int limit, output int at, output logic [3:0] en,
                            output logic [3:0] wen, output logic [3:0] ad, output logic [31:0] wd);
        at = -1; en = '0; wen = '0; ad = '0; wd = '0;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge spy_clock);
            if (bus.req_ack) begin
                at = cyc; en = bus.sb_en; wen = bus.sb_wr_en; ad = bus.sb_addr; wd = bus.sb_wr_data;
            end
        end
        bus.req_vld = 1'b0;
        if (at < 0) check({tag, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_rd(input string tag, output int at, output logic [31:0] d, output logic err);
        at = -1; d = '0; err = 1'b0;
        for (int i = 0; i < 10 && at < 0; i++) begin
            @(negedge spy_clock);
            if (bus.rd_vld) begin
                at = cyc; d = bus.rd_data; err = bus.rd_err;
            end
        end
        if (at < 0) check({tag, "_rd_vld_timeout"}, 0, 1);
    endtask

    task automatic mon_init(output int cycles, output int bad, output logic [31:0] d5);
        cycles = 0; bad = 0; d5 = '0;
        for (int i = 0; i < 10 && !init_busy; i++) @(negedge spy_clock);
        while (init_busy && cycles < 40) begin
            if (bus.sb_en != 4'hF || bus.sb_wr_en != 4'hF || bus.sb_addr != 4'(cycles) ||
                bus.sb_wr_data != exp_init(cycles) || init_done) bad++;
            if (bus.sb_addr == 4'd5) d5 = bus.sb_wr_data;
            cycles++;
            @(negedge spy_clock);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, ta, t2, tr, cycles, bad;
        logic [3:0] en, wen, ad;
        logic [31:0] wd, rd, d5;
        logic err;
        bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_ch = '0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge spy_clock);
        axi_reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge spy_clock);
            if (outs != '0) bad++;
        end
        check("reset_quiet_cycles", bad, 0);
        check("reset_init_done", init_done, 0);

        init_start = 1'b1;
        @(negedge spy_clock);
        init_start = 1'b0;
        mon_init(cycles, bad, d5);
        check("init_cycles", cycles, 16);
        check("init_strobe_errs", bad, 0);
        check("init_addr5_data", d5, exp_init(5));
        check("init_done_set", init_done, 1);

        start_req(1'b1, 3'd2, 4'd7, 32'hCAFE0001);
        wait_ack("wr", 10, ta, en, wen, ad, wd);
        check("wr_sb_en", en, 4'b0100);
        check("wr_sb_wr_en", wen, 4'b0100);
        check("wr_sb_addr", ad, 7);
        check("wr_sb_data", wd, 32'hCAFE0001);

        start_req(1'b0, 3'd2, 4'd7, 32'h0);
        wait_ack("rd", 10, ta, en, wen, ad, wd);
        check("rd_sb_en", en, 4'b0100);
        check("rd_sb_wr_en", wen, 4'b0000);
        wait_rd("rd", tr, rd, err);
        check("rd_latency", tr - ta, 2);
        check("rd_data", rd, 32'hCAFE0001);
        check("rd_err_clear", err, 0);
        @(negedge spy_clock);
        check("rd_data_after_vld", {bus.rd_vld, bus.rd_data}, 0);

        start_req(1'b0, 3'd1, 4'd5, 32'h0);
        wait_ack("rd_init", 10, ta, en, wen, ad, wd);
        wait_rd("rd_init", tr, rd, err);
        check("rd_init_word", rd, exp_init(5));

        start_req(1'b0, 3'd2, 4'd7, 32'h0);
        wait_ack("b2b_a", 10, ta, en, wen, ad, wd);
        start_req(1'b0, 3'd0, 4'd3, 32'h0);
        wait_ack("b2b_b", 10, t2, en, wen, ad, wd);
        check("rd_b2b_period", t2 - ta, 3);
        wait_rd("b2b_b", tr, rd, err);
        check("rd_b2b_data", rd, exp_init(3));

        t0 = cyc;
        init_start = 1'b1;
        start_req(1'b0, 3'd2, 4'd7, 32'h0);
        @(negedge spy_clock);
        init_start = 1'b0;
        wait_ack("rd_vs_init", 40, ta, en, wen, ad, wd);
        check("rd_vs_init_delay", (ta - t0) >= 17, 1);
        check("rd_vs_init_done", init_done, 1);
        wait_rd("rd_vs_init", tr, rd, err);
        check("rd_vs_init_data", rd, exp_init(7));

        t0 = cyc;
        init_start = 1'b1;
        start_req(1'b1, 3'd3, 4'd2, 32'h12345678);
        @(negedge spy_clock);
        init_start = 1'b0;
        wait_ack("wr_vs_init", 40, ta, en, wen, ad, wd);
        check("wr_vs_init_delay", (ta - t0) >= 17, 1);
        check("wr_vs_init_done", init_done, 1);
        check("wr_vs_init_wr_en", wen, 4'b1000);
        start_req(1'b0, 3'd3, 4'd2, 32'h0);
        wait_ack("rd_after_wr", 10, ta, en, wen, ad, wd);
        wait_rd("rd_after_wr", tr, rd, err);
        check("rd_after_wr_data", rd, 32'h12345678);

        start_req(1'b0, 3'd5, 4'd1, 32'h0);
        wait_ack("rd_bad_ch", 10, ta, en, wen, ad, wd);
        check("rd_bad_ch_no_en", en, 4'b0000);
        wait_rd("rd_bad_ch", tr, rd, err);
        check("rd_bad_ch_err", err, 1);
        check("rd_bad_ch_data", rd, 0);
        start_req(1'b1, 3'd6, 4'd1, 32'hDEAD0000);
        wait_ack("wr_bad_ch", 10, ta, en, wen, ad, wd);
        check("wr_bad_ch_no_strobe", {en, wen}, 0);

        @(negedge spy_clock);
        init_start = 1'b1;
        @(negedge spy_clock);
        init_start = 1'b0;
        for (int i = 0; i < 20 && !(init_busy && bus.sb_addr == 4'd9); i++) @(negedge spy_clock);
        check("rst_reach_addr9", {init_busy, bus.sb_addr}, {1'b1, 4'd9});
        axi_reset_n = 1'b0;
        @(negedge spy_clock);
        check("rst_mid_init_outs", outs, 0);
        check("rst_mid_init_done", init_done, 0);
        axi_reset_n = 1'b1;
        @(negedge spy_clock);
        init_start = 1'b1;
        @(negedge spy_clock);
        init_start = 1'b0;
        mon_init(cycles, bad, d5);
        check("reinit_cycles", cycles, 16);
        check("reinit_strobe_errs", bad, 0);
        check("reinit_done", init_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
